nios_system_key_scanner: RTL
============================

NIOS_SYSTEM_KEY_SCANNER -- requirements
Module: nios_system_key_scanner

Interface
REQ-001 Params SHALL be (name, default, meaning): NUM_KEYS, 8, key PIO channels polled; SCAN_DIV, 50000, clk cycles between scan starts; DEBOUNCE_SCANS, 4, consecutive equal samples to accept a change; FIFO_DEPTH, 8, event FIFO entries (power of 2).
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 system clock; reset in 1 synchronous active-high reset.
REQ-003 pio_chan_sel out 3: selects the key PIO whose readdata is routed to pio_readdata.
REQ-004 pio_address out 2: shared PIO address, driven 0 during scans, 0 otherwise.
REQ-005 pio_readdata in 32: selected PIO readdata, registered by the PIO (1-cycle latency); only bit 0 used.
REQ-006 avs_address in 2, avs_read in 1, avs_write in 1, avs_writedata in 32, avs_readdata out 32: CPU Avalon-MM slave.
REQ-007 irq out 1: level interrupt to CPU.

Function
REQ-008 Scan FSM states SHALL be IDLE, SELECT, WAIT, SAMPLE; reset state IDLE.
REQ-009 A free-running tick counter SHALL pulse every SCAN_DIV cycles; IDLE->SELECT on tick, channel index = 0.
REQ-010 SELECT drives pio_chan_sel = index for one cycle, then WAIT (1 cycle), then SAMPLE captures pio_readdata[0] for that channel.
REQ-011 SAMPLE->SELECT with index+1 if index < NUM_KEYS-1, else SAMPLE->IDLE; full scan = 3*NUM_KEYS cycles.
REQ-012 A tick arriving while not IDLE SHALL be ignored (no queued scan).
REQ-013 pio_chan_sel SHALL hold its value through WAIT and SAMPLE.
REQ-014 Per channel: if sample != debounced state, stable counter increments, else clears; at DEBOUNCE_SCANS the debounced bit toggles, counter clears.
REQ-015 Each debounced toggle SHALL push event {type (1=press, 0=release), channel[2:0]} into the FIFO.
REQ-016 FIFO full with no pop SHALL drop the event and set sticky overflow.
REQ-017 avs read latency SHALL be 1 cycle (registered avs_readdata, 0 when no read).
REQ-018 Read addr 0: avs_readdata = {valid[31], 27'b0, type[3], channel[2:0]}; pops if non-empty; empty returns 0, no pop.
REQ-019 Read addr 1: debounced key state in bits [NUM_KEYS-1:0], zero-extended.
REQ-020 Addr 2: R/W irq_enable bit 0; addr 3 read: {overflow[31], 27'b0, count[3:0]}; addr 3 write with bit 31 = 1 clears overflow.
REQ-021 Push and pop same cycle SHALL both occur (count unchanged), including when full.
REQ-022 irq = irq_enable & (count != 0), registered.
REQ-023 Writes to addr 0/1 SHALL be ignored.

Reset
REQ-024 On reset: FSM IDLE, index 0, tick counter 0, pio_chan_sel 0, pio_address 0, debounced state 0 (all released), stable counters 0, FIFO empty, overflow 0, irq_enable 0, irq 0, avs_readdata 0.
REQ-025 Reset mid-scan SHALL abort the scan with no partial event pushed.

Structure
REQ-026 Shared package SHALL hold FSM state encoding, event field widths/positions and register address constants.
REQ-027 The event FIFO SHALL be one sub-module, nios_system_key_event_fifo; the rest stays flat.

Verification
REQ-028 Channel 2 held 1 for 4 scans (SCAN_DIV=16) -> addr 1 reads 0x04; addr 0 reads 0x8000000A; next addr 0 read 0.
REQ-029 Channel 5 glitches high for 3 scans then low -> no event, addr 1 stays 0x00.
REQ-030 All 8 keys pressed then released, no reads (16 events) -> count 8, overflow 1; write addr 3 0x80000000 -> overflow 0.
REQ-031 irq_enable=1, one press event -> irq 1 next cycle; read addr 0 -> irq 0 two cycles later.
REQ-032 Assert reset during WAIT of channel 3 with channel 3 mid-debounce -> all outputs 0, count 0, next scan restarts at channel 0.
REQ-033 FIFO full, press event and addr 0 read in same cycle -> oldest event returned, count stays 8, overflow stays 0.

Source files
------------

// File: rtl/nios_system_key_scanner_pkg.sv
// Shared definitions for the key scanner: scan FSM encoding, event layout
// and CPU register map.
package nios_system_key_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SAMPLE = 2'd3
  } scan_state_t;

  localparam int EVT_CHAN_W   = 3;
  localparam int EVT_TYPE_POS = 3;
  localparam int EVT_W        = EVT_TYPE_POS + 1;
  localparam int RD_VALID_POS = 31;
  localparam int OVF_POS      = 31;

  localparam logic [1:0] ADDR_EVENT  = 2'd0;
  localparam logic [1:0] ADDR_KEYS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  function automatic logic [EVT_W-1:0] make_event(input logic pressed,
                                                  input logic [EVT_CHAN_W-1:0] chan);
    return {pressed, chan};
  endfunction

endpackage

// File: rtl/nios_system_key_event_fifo.sv
// Key event FIFO. A pop frees a slot in the same cycle, so push and pop
// together always both succeed, even when full.
module nios_system_key_event_fifo
  import nios_system_key_scanner_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = EVT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nios_system_key_scanner.sv
// Polls key PIOs one channel at a time, debounces each key and reports
// press/release events to the CPU through a small Avalon-MM register file.
//
//   state     | meaning
//   ST_IDLE   | waiting for the scan tick
//   ST_SELECT | pio_chan_sel driven with the current channel
//   ST_WAIT   | PIO readdata register catching up
//   ST_SAMPLE | pio_readdata[0] captured and debounced
module nios_system_key_scanner
  import nios_system_key_scanner_pkg::*;
#(
  parameter int NUM_KEYS       = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic [2:0]  pio_chan_sel,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam int IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_SCANS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_KEYS - 1);

  scan_state_t         state;
  logic [IDX_W-1:0]    idx;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] key_state;
  logic [DB_W-1:0]     stable_cnt [NUM_KEYS];

  logic                sample;
  logic                differs;
  logic                toggle;
  logic [EVT_W-1:0]    evt_data;

  logic                fifo_pop;
  logic [EVT_W-1:0]    fifo_pop_data;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  logic [3:0]          count4;

  logic                irq_enable;
  logic                overflow;
  logic                unused_bits;

  assign pio_address = 2'b00;
  assign unused_bits = ^{pio_readdata[31:1], avs_writedata[30:1]};

  // Down-counter: tick fires whenever it sits at zero, then reloads.
  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= TICK_RELOAD;
    else           tick_cnt <= tick_cnt - 1'b1;
  end

  assign sample   = pio_readdata[0];
  assign differs  = (sample != key_state[idx]);
  assign toggle   = (state == ST_SAMPLE) && differs && (stable_cnt[idx] == DB_LAST);
  assign evt_data = make_event(sample, EVT_CHAN_W'(idx));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      pio_chan_sel <= '0;
      key_state    <= '0;
      for (int i = 0; i < NUM_KEYS; i++) stable_cnt[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state        <= ST_SELECT;
            idx          <= '0;
            pio_chan_sel <= '0;
          end
        end
        ST_SELECT: state <= ST_WAIT;
        ST_WAIT:   state <= ST_SAMPLE;
        ST_SAMPLE: begin
          if (toggle) begin
            key_state[idx]  <= sample;
            stable_cnt[idx] <= '0;
          end else if (differs) begin
            stable_cnt[idx] <= stable_cnt[idx] + 1'b1;
          end else begin
            stable_cnt[idx] <= '0;
          end
          if (idx == IDX_LAST) begin
            state <= ST_IDLE;
          end else begin
            idx          <= idx + 1'b1;
            pio_chan_sel <= EVT_CHAN_W'(idx + 1'b1);
            state        <= ST_SELECT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_pop = avs_read && (avs_address == ADDR_EVENT) && !fifo_empty;
  assign count4   = 4'(fifo_count);

  nios_system_key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_event_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (toggle),
    .push_data (evt_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata <= '0;
      irq_enable   <= 1'b0;
      overflow     <= 1'b0;
      irq          <= 1'b0;
    end else begin
      avs_readdata <= '0;
      if (avs_read) begin
        case (avs_address)
          ADDR_EVENT:  avs_readdata <= fifo_empty ? 32'd0 : {1'b1, 27'd0, fifo_pop_data};
          ADDR_KEYS:   avs_readdata <= 32'(key_state);
          ADDR_IRQ_EN: avs_readdata <= {31'd0, irq_enable};
          ADDR_STATUS: avs_readdata <= {overflow, 27'd0, count4};
          default:     avs_readdata <= '0;
        endcase
      end
      if (avs_write && avs_address == ADDR_IRQ_EN) irq_enable <= avs_writedata[0];
      if (avs_write && avs_address == ADDR_STATUS && avs_writedata[OVF_POS]) overflow <= 1'b0;
      // A dropped event wins over a same-cycle clear so it is never lost silently.
      if (toggle && fifo_full && !fifo_pop) overflow <= 1'b1;
      irq <= irq_enable && (fifo_count != '0);
    end
  end

endmodule
